dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder on the CPU's dmem bus. It answers the core's `dmem_ren`/`dmem_wen`/`dmem_byt` accesses with a byte-lane-writable RAM and a small memory-mapped I/O window. The window holds a millisecond timer that drives the core's `irq` input, and an LED output register. It sits beside the CPU in the top level, opposite the core's data-memory master port.

## Interface
Parameters:
- `CLOCK_HZ`, default 27_000_000: clk frequency; the timer tick period is CLOCK_HZ/1000 cycles (minimum 1).
- `RAM_WORDS`, default 1024: 16-bit RAM words, power of two; byte range 0 … 2*RAM_WORDS-1.
- `MMIO_BASE`, default `ADDR_WIDTH'hFF00`: byte base address of the 8-byte register window.
- `INIT_FILE`, default "": optional `$readmemh` image for the RAM.

Ports:
- `clk` in, 1 bit: clock.
- `rst` in, 1 bit: reset, asynchronous, active-high.
- `dmem_addr` in, `ADDR_WIDTH` bits: byte address.
- `dmem_ren` in, 1 bit: read strobe.
- `dmem_wen` in, 1 bit: write strobe.
- `dmem_byt` in, 1 bit: 1 = byte access, 0 = word access.
- `dmem_wdata` in, 16 bits: write data; for byte writes the data is already placed in the addressed lane.
- `dmem_rdata` out, 16 bits: registered read data.
- `irq` out, 1 bit: timer interrupt request, level.
- `led` out, 8 bits: LED register.

## Operation
- **Decode**
  - RAM when `dmem_addr < 2*RAM_WORDS`; the word index is `dmem_addr[..:1]`.
  - MMIO when `dmem_addr[ADDR_WIDTH-1:3] == MMIO_BASE[ADDR_WIDTH-1:3]`.
  - Anything else is unmapped: reads return 0 and writes are ignored.
- **Word write** (`byt=0`): writes all 16 bits; `addr[0]` is ignored.
- **Byte write** (`byt=1`):
  - `addr[0]=0` writes `wdata[7:0]` into the low lane.
  - `addr[0]=1` writes `wdata[15:8]` into the high lane.
  - The other lane is unchanged. The same rule applies to MMIO registers.
- **Reads**: always return the full aligned word; the core selects the lane. `byt` is ignored for reads.
- **MMIO registers** (offset from MMIO_BASE):
  - +0 CTRL: bit0 EN, bit1 IE, bit2 PEND. PEND reads as the pending flag; writing 1 to PEND clears it, writing 0 has no effect.
  - +2 CNT: ms counter, read/write.
  - +4 CMP: compare value, read/write.
  - +6 LED: low 8 bits drive `led`; the high byte reads 0.
- **Timer**
  - The prescaler counts 0 … CLOCK_HZ/1000-1 and emits a 1-cycle `tick` on wrap. It runs only while EN=1 and is cleared to 0 when EN=0.
  - On `tick`: if CNT==CMP, then CNT←0 and PEND←1; otherwise CNT←CNT+1, wrapping 0xFFFF→0.
  - CMP=0 sets PEND on every tick, with CNT held at 0.
- `irq` = PEND & IE, taken from registered state with no combinational path from bus inputs.

## Timing
- **Read latency**: 1 cycle. `dmem_rdata` updates at the posedge where `ren=1` and holds until the next read.
- **Writes**: take effect at the posedge where `wen=1`.
- **`ren` and `wen` in the same cycle, same word**: `rdata` returns the pre-write value (read-before-write), for both RAM and MMIO.
- **Simultaneous events**
  - CPU write to CNT in the same cycle as `tick`: the CPU write wins.
  - PEND set by the timer in the same cycle as a W1C write: the set wins.
- **Reset values**:
  - `dmem_rdata`=0, `irq`=0, `led`=0.
  - CTRL=0, CNT=0, CMP=0xFFFF, prescaler=0.
  - RAM is not reset; it holds INIT_FILE contents or is undefined.
- **Reset mid-access or while PEND=1**: `irq` and `rdata` go to 0 asynchronously. A write strobed during reset is dropped.

## Structure
- Package `dmem_pkg` holds the register offsets (`REG_CTRL`=0, `REG_CNT`=2, `REG_CMP`=4, `REG_LED`=6) and the CTRL bit indices (`CTRL_EN`, `CTRL_IE`, `CTRL_PEND`).
- Sub-module `mmio_timer` holds the prescaler, CNT, CMP, CTRL and `irq`. It has a register-write port (offset, lane enables, data) and a read port.
- The top level holds the address decode, the byte-lane RAM (two 8-bit arrays or one array with lane enables), the LED register and the read-data mux/register.

## Test plan
- **Word round-trip**: word write 0xBEEF @0x0100, then read @0x0100 → `rdata`=0xBEEF one cycle after `ren`.
- **Byte lanes**:
  - Word write 0xAAAA @0x0080.
  - Byte write `wdata`=0x1200 @0x0081 → read @0x0080 gives 0x12AA.
  - Byte write `wdata`=0x0034 @0x0080 → read gives 0x1234.
- **Read-before-write**: with @0x0200=0x1111, assert `ren` and `wen` (`wdata`=0x2222) in the same cycle → `rdata`=0x1111; next read gives 0x2222.
- **Timer**:
  - Setup: CLOCK_HZ=1000, write CMP=3, then CTRL=0x3.
  - Counting: CNT goes 0,1,2,3; on the 4th tick PEND=1 and `irq`=1 the cycle after, with CNT=0.
  - Clear: write CTRL=0x7 → `irq`=0 the next cycle while EN/IE stay 1.
- **Precedence**: a CNT write of 0x0005 coinciding with `tick` → CNT reads 0x0005.
- **Reset and unmapped access**:
  - Assert `rst` while `irq`=1 → `irq`=0, `led`=0, `rdata`=0 immediately.
  - After release, CMP reads 0xFFFF.
  - Read of unmapped address 0xF000 → 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder:
// MMIO register offsets and CTRL bit positions.
package dmem_pkg;

   localparam int ADDR_WIDTH = 16;

   localparam logic [2:0] REG_CTRL = 3'd0;
   localparam logic [2:0] REG_CNT  = 3'd2;
   localparam logic [2:0] REG_CMP  = 3'd4;
   localparam logic [2:0] REG_LED  = 3'd6;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_IE   = 1;
   localparam int CTRL_PEND = 2;

endpackage

// File: rtl/mmio_timer.sv
// Millisecond timer: prescaler, CNT/CMP compare, CTRL
// with write-1-to-clear PEND, and the level irq.
module mmio_timer
   import dmem_pkg::*;
#(
   parameter int CLOCK_HZ = 27_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [1:0]  wr_idx,
   input  logic [1:0]  wr_be,
   input  logic [15:0] wr_data,
   input  logic [1:0]  rd_idx,
   output logic [15:0] rd_data,
   output logic        irq
);

   localparam int DIV =
      (CLOCK_HZ / 1000 > 1) ? CLOCK_HZ / 1000 : 1;
   localparam logic [31:0] PRESC_MAX = 32'(DIV - 1);

   localparam logic [1:0] IDX_CTRL = REG_CTRL[2:1];
   localparam logic [1:0] IDX_CNT  = REG_CNT[2:1];
   localparam logic [1:0] IDX_CMP  = REG_CMP[2:1];

   logic [31:0] presc_q, presc_d;
   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic        pend_q, pend_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] cmp_q, cmp_d;
   logic [15:0] mask;
   logic        tick, hit;
   logic        wr_ctrl, wr_cnt, wr_cmp;

   always_comb begin
      mask    = {{8{wr_be[1]}}, {8{wr_be[0]}}};
      wr_ctrl = wr_en && wr_idx == IDX_CTRL && wr_be[0];
      wr_cnt  = wr_en && wr_idx == IDX_CNT;
      wr_cmp  = wr_en && wr_idx == IDX_CMP;
      tick    = en_q && presc_q == PRESC_MAX;
      hit     = cnt_q == cmp_q;

      presc_d = (!en_q || tick) ? '0 : presc_q + 32'd1;
      en_d    = en_q;
      ie_d    = ie_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      cmp_d   = cmp_q;

      if (wr_ctrl) begin
         en_d = wr_data[CTRL_EN];
         ie_d = wr_data[CTRL_IE];
         if (wr_data[CTRL_PEND])
            pend_d = 1'b0;
      end
      // timer set beats a same-cycle clear
      if (tick && hit)
         pend_d = 1'b1;

      if (wr_cnt)
         cnt_d = (cnt_q & ~mask) | (wr_data & mask);
      else if (tick)
         cnt_d = hit ? '0 : cnt_q + 16'd1;

      if (wr_cmp)
         cmp_d = (cmp_q & ~mask) | (wr_data & mask);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         en_q    <= 1'b0;
         ie_q    <= 1'b0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         cmp_q   <= 16'hFFFF;
      end else begin
         presc_q <= presc_d;
         en_q    <= en_d;
         ie_q    <= ie_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         cmp_q   <= cmp_d;
      end
   end

   always_comb begin
      rd_data = '0;
      unique case (1'b1)
         rd_idx == IDX_CTRL: begin
            rd_data[CTRL_EN]   = en_q;
            rd_data[CTRL_IE]   = ie_q;
            rd_data[CTRL_PEND] = pend_q;
         end
         rd_idx == IDX_CNT: rd_data = cnt_q;
         rd_idx == IDX_CMP: rd_data = cmp_q;
         default:           rd_data = '0;
      endcase
   end

   assign irq = pend_q & ie_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem bus slave: byte-lane RAM, timer/LED register
// window and the registered read-data path.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int                    CLOCK_HZ  = 27_000_000,
   parameter int                    RAM_WORDS = 1024,
   parameter logic [ADDR_WIDTH-1:0] MMIO_BASE = 16'hFF00,
   parameter                        INIT_FILE = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] dmem_addr,
   input  logic                  dmem_ren,
   input  logic                  dmem_wen,
   input  logic                  dmem_byt,
   input  logic [15:0]           dmem_wdata,
   output logic [15:0]           dmem_rdata,
   output logic                  irq,
   output logic [7:0]            led
);

   localparam int IDX_W = $clog2(RAM_WORDS);
   localparam logic [ADDR_WIDTH:0] RAM_BYTES =
      (ADDR_WIDTH + 1)'(2 * RAM_WORDS);
   localparam logic [1:0] IDX_LED = REG_LED[2:1];

   logic [15:0]      mem [RAM_WORDS];
   logic [IDX_W-1:0] ram_idx;
   logic [1:0]       reg_idx;
   logic [1:0]       be;
   logic             is_ram, is_mmio;
   logic             ram_we, mmio_we;
   logic [15:0]      tmr_rdata;
   logic [15:0]      rdata_q, rdata_d;
   logic [7:0]       led_q, led_d;

   always_comb begin
      is_ram  = {1'b0, dmem_addr} < RAM_BYTES;
      is_mmio = dmem_addr[ADDR_WIDTH-1:3]
             == MMIO_BASE[ADDR_WIDTH-1:3];
      ram_idx = dmem_addr[IDX_W:1];
      reg_idx = dmem_addr[2:1];
      be      = !dmem_byt   ? 2'b11 :
                dmem_addr[0] ? 2'b10 : 2'b01;
      // strobes seen during reset must not land
      ram_we  = dmem_wen && is_ram && !rst;
      mmio_we = dmem_wen && !is_ram && is_mmio;
   end

   always_ff @(posedge clk) begin
      if (ram_we && be[0])
         mem[ram_idx][7:0] <= dmem_wdata[7:0];
      if (ram_we && be[1])
         mem[ram_idx][15:8] <= dmem_wdata[15:8];
   end

   mmio_timer #(
      .CLOCK_HZ (CLOCK_HZ)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (mmio_we),
      .wr_idx  (reg_idx),
      .wr_be   (be),
      .wr_data (dmem_wdata),
      .rd_idx  (reg_idx),
      .rd_data (tmr_rdata),
      .irq     (irq)
   );

   always_comb begin
      led_d = led_q;
      if (mmio_we && reg_idx == IDX_LED && be[0])
         led_d = dmem_wdata[7:0];

      rdata_d = rdata_q;
      if (dmem_ren) begin
         unique case (1'b1)
            is_ram:  rdata_d = mem[ram_idx];
            is_mmio: rdata_d = (reg_idx == IDX_LED)
                             ? {8'h00, led_q} : tmr_rdata;
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
         led_q   <= '0;
      end else begin
         rdata_q <= rdata_d;
         led_q   <= led_d;
      end
   end

   assign dmem_rdata = rdata_q;
   assign led        = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: reads queue expected data, a monitor
// compares rdata on the negedge after each read edge.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] dmem_addr;
   logic        dmem_ren;
   logic        dmem_wen;
   logic        dmem_byt;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        irq;
   logic [7:0]  led;

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_q [$];
   string       name_q [$];

   dmem_responder #(
      .CLOCK_HZ (1000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .dmem_addr  (dmem_addr),
      .dmem_ren   (dmem_ren),
      .dmem_wen   (dmem_wen),
      .dmem_byt   (dmem_byt),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .irq        (irq),
      .led        (led)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [15:0] act,
                      logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // one bus cycle; returns #1 after the sampling edge
   task automatic bus(logic r, logic w, logic b,
                      logic [15:0] a, logic [15:0] d);
      dmem_ren   = r;
      dmem_wen   = w;
      dmem_byt   = b;
      dmem_addr  = a;
      dmem_wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(logic [15:0] a, logic [15:0] d);
      bus(1'b0, 1'b1, 1'b0, a, d);
   endtask

   task automatic wrb(logic [15:0] a, logic [15:0] d);
      bus(1'b0, 1'b1, 1'b1, a, d);
   endtask

   task automatic rd(logic [15:0] a, logic [15:0] e,
                     string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      bus(1'b1, 1'b0, 1'b0, a, 16'h0);
   endtask

   task automatic idle();
      bus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   initial begin : monitor
      logic was;
      logic [15:0] e;
      string nm;
      forever begin
         @(posedge clk);
         was = dmem_ren && !rst;
         @(negedge clk);
         if (was) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_read: got %h want none",
                        dmem_rdata);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               chk(nm, dmem_rdata, e);
            end
         end
      end
   end

   localparam logic [15:0] CTRL = 16'hFF00;
   localparam logic [15:0] CNT  = 16'hFF02;
   localparam logic [15:0] CMP  = 16'hFF04;
   localparam logic [15:0] LEDR = 16'hFF06;

   initial begin
      rst        = 1'b1;
      dmem_addr  = '0;
      dmem_ren   = 1'b0;
      dmem_wen   = 1'b0;
      dmem_byt   = 1'b0;
      dmem_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", dmem_rdata, 16'h0);
      chk("rst_irq", {15'h0, irq}, 16'h0);
      chk("rst_led", {8'h0, led}, 16'h0);
      rst = 1'b0;
      idle();

      rd(CMP, 16'hFFFF, "cmp_reset");
      rd(CTRL, 16'h0000, "ctrl_reset");
      rd(CNT, 16'h0000, "cnt_reset");

      wr(16'h0100, 16'hBEEF);
      rd(16'h0100, 16'hBEEF, "word_rt");

      wr(16'h0080, 16'hAAAA);
      wrb(16'h0081, 16'h1200);
      rd(16'h0080, 16'h12AA, "byte_hi");
      wrb(16'h0080, 16'h0034);
      rd(16'h0080, 16'h1234, "byte_lo");
      rd(16'h0081, 16'h1234, "odd_read");

      wr(16'h0200, 16'h1111);
      exp_q.push_back(16'h1111);
      name_q.push_back("rbw_old");
      bus(1'b1, 1'b1, 1'b0, 16'h0200, 16'h2222);
      rd(16'h0200, 16'h2222, "rbw_new");

      wr(LEDR, 16'h5AC3);
      chk("led_word", {8'h0, led}, 16'h00C3);
      rd(LEDR, 16'h00C3, "led_read");
      wrb(16'hFF07, 16'h7700);
      chk("led_hilane", {8'h0, led}, 16'h00C3);
      wrb(LEDR, 16'h0011);
      chk("led_lolane", {8'h0, led}, 16'h0011);

      wr(16'hF000, 16'h1234);
      rd(16'hF000, 16'h0000, "unmapped");
      rd(16'h0800, 16'h0000, "past_ram");

      // CLOCK_HZ=1000: one tick every enabled cycle
      wr(CMP, 16'h0003);
      wr(CTRL, 16'h0003);
      rd(CNT, 16'h0000, "cnt0");
      rd(CNT, 16'h0001, "cnt1");
      rd(CNT, 16'h0002, "cnt2");
      chk("irq_early", {15'h0, irq}, 16'h0);
      rd(CNT, 16'h0003, "cnt3");
      chk("irq_set", {15'h0, irq}, 16'h1);
      wr(CTRL, 16'h0007);
      chk("irq_clr", {15'h0, irq}, 16'h0);
      rd(CTRL, 16'h0003, "ctrl_clr");
      rd(CNT, 16'h0002, "cnt_wrap");
      wr(CTRL, 16'h0007);
      chk("set_wins", {15'h0, irq}, 16'h1);
      rd(CTRL, 16'h0007, "ctrl_set");

      wr(CMP, 16'h0100);
      wr(CNT, 16'h0005);
      rd(CNT, 16'h0005, "cnt_wr_wins");
      rd(CNT, 16'h0006, "cnt_after");

      rd(16'h0100, 16'hBEEF, "pre_rst");
      idle();
      chk("irq_pre_rst", {15'h0, irq}, 16'h1);
      #3 rst = 1'b1;
      #1;
      chk("arst_irq", {15'h0, irq}, 16'h0);
      chk("arst_led", {8'h0, led}, 16'h0);
      chk("arst_rdata", dmem_rdata, 16'h0);
      @(posedge clk);
      #1;
      bus(1'b1, 1'b1, 1'b0, 16'h0100, 16'hDEAD);
      bus(1'b1, 1'b1, 1'b0, 16'h0100, 16'hDEAD);
      dmem_ren = 1'b0;
      dmem_wen = 1'b0;
      rst = 1'b0;
      idle();

      rd(CMP, 16'hFFFF, "cmp_after_rst");
      rd(CTRL, 16'h0000, "ctrl_after_rst");
      rd(16'h0100, 16'hBEEF, "wr_in_rst_drop");
      rd(16'hF000, 16'h0000, "unmapped2");
      idle();
      idle();
      chk("irq_after_rst", {15'h0, irq}, 16'h0);
      chk("sb_drained", 16'(exp_q.size()), 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule
